// File: rtl/servo_pwm_gen.sv
`default_nettype none
// ============================================================================
// Module   : servo_pwm_gen
// Brief    : Servo PWM generator with frame-aligned width updates and an
//            optional latched over-current fault (SERVO_OC_PROTECT_EN).
// Revision : 1.0
// ============================================================================
module servo_pwm_gen #(
  parameter int CLK_HZ   = 50_000_000,
  parameter int FRAME_US = 20000,
  parameter int MIN_US   = 1000,
  parameter int MAX_US   = 2000,
  parameter int ILIM_MA  = 4000,
  parameter int OC_TICKS = 50000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  cmd_grades,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [11:0] current_ma,
  input  logic        fault_clr,
  output logic        pwm_out,
  output logic        frame_start,
  output logic        fault
);

  localparam int TPU         = CLK_HZ / 1_000_000;
  localparam int FRAME_TICKS = FRAME_US * TPU;
  localparam int MIN_TICKS   = MIN_US * TPU;
  localparam int STEP_TICKS  = ((MAX_US - MIN_US) * TPU) / 180;

  localparam logic [19:0] FRAME_LAST = 20'(FRAME_TICKS - 1);
  localparam logic [19:0] MIN_T      = 20'(MIN_TICKS);
  localparam logic [19:0] STEP_T     = 20'(STEP_TICKS);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FAULT = 2'd2
  } state_t;

  state_t      state, state_next;
  logic [19:0] cnt, active, pending, ticks;
  logic [7:0]  angle_sat;
  logic        pending_valid, pending_valid_next, resume_hold;
  logic        accept, wrap, oc_trip, clr_ok;

  assign accept    = cmd_valid && cmd_ready;
  assign wrap      = (state != IDLE) && (cnt == FRAME_LAST);
  assign angle_sat = (cmd_grades > 8'd180) ? 8'd180 : cmd_grades;
  assign ticks     = MIN_T + 20'(angle_sat) * STEP_T;

`ifdef SERVO_OC_PROTECT_EN
  localparam int              OC_W   = $clog2(OC_TICKS + 1);
  localparam logic [OC_W-1:0] OC_MAX = OC_W'(OC_TICKS);
  localparam logic [11:0]     ILIM   = 12'(ILIM_MA);

  logic [OC_W-1:0] oc_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      oc_cnt <= '0;
    end else if (current_ma > ILIM) begin
      if (oc_cnt != OC_MAX) oc_cnt <= oc_cnt + 1'b1;
    end else begin
      oc_cnt <= '0;
    end
  end

  assign oc_trip = (oc_cnt == OC_MAX);
  assign clr_ok  = fault_clr && (oc_cnt == '0);
`else
  logic unused_inputs;
  assign unused_inputs = ^{current_ma, fault_clr, 12'(ILIM_MA), 16'(OC_TICKS)};
  assign oc_trip = 1'b0;
  assign clr_ok  = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept)  state_next = RUN;
      RUN:     if (oc_trip) state_next = FAULT;
      FAULT:   if (clr_ok)  state_next = RUN;
      default: state_next = IDLE;
    endcase
  end

  // An accept always finds the pending slot empty, so it never collides with
  // the wrap-time transfer of pending into active.
  always_comb begin
    pending_valid_next = pending_valid;
    if (wrap && pending_valid)      pending_valid_next = 1'b0;
    if (accept && (state != IDLE))  pending_valid_next = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt           <= '0;
      active        <= '0;
      pending       <= '0;
      pending_valid <= 1'b0;
      cmd_ready     <= 1'b0;
      pwm_out       <= 1'b0;
      frame_start   <= 1'b0;
      fault         <= 1'b0;
      resume_hold   <= 1'b0;
    end else begin
      pending_valid <= pending_valid_next;
      cmd_ready     <= !pending_valid_next;
      if (accept && (state != IDLE)) pending <= ticks;

      if (state == IDLE) begin
        cnt <= '0;
        if (accept) active <= ticks;
      end else begin
        cnt <= wrap ? 20'd0 : cnt + 20'd1;
        if (wrap && pending_valid) active <= pending;
      end

      frame_start <= (state != IDLE) && (cnt == 20'd0);
      pwm_out     <= (state == RUN) && !resume_hold && (cnt < active);

      // After a fault clear, stay low until the next frame boundary.
      if ((state == FAULT) && clr_ok) resume_hold <= !wrap;
      else if (wrap)                  resume_hold <= 1'b0;

      if (oc_trip)     fault <= 1'b1;
      else if (clr_ok) fault <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: doc/servo_pwm_gen.md
# servo_pwm_gen

Synthesizable servo PWM generator that drives `pwm_out` of the servo top level. It accepts angle commands in integer degrees over a valid/ready handshake and converts each to a pulse width. It emits a fixed 20 ms frame with the new width applied only at frame boundaries. It also watches the sampled motor current and latches an over-current fault that forces the output low.

## Interface
Parameters:
- `CLK_HZ`, 50_000_000, clock frequency
- `FRAME_US`, 20000, PWM frame length in µs
- `MIN_US`, 1000, pulse width at 0°
- `MAX_US`, 2000, pulse width at 180°
- `ILIM_MA`, 4000, over-current threshold in mA
- `OC_TICKS`, 50000, consecutive over-limit cycles before a fault is declared

Ports:
- `clk` in 1: single clock
- `rst` in 1: synchronous, active-high reset
- `cmd_grades` in 8: commanded angle in degrees, unsigned
- `cmd_valid` in 1: command present
- `cmd_ready` out 1: command register free
- `current_ma` in 12: measured current in mA, unsigned, sampled every cycle
- `fault_clr` in 1: single-cycle fault-clear request
- `pwm_out` out 1: servo pulse train, registered
- `frame_start` out 1: one-cycle pulse on the first cycle of each frame
- `fault` out 1: latched over-current fault

## Operation
- Derived constants:
  - TPU = CLK_HZ/1_000_000
  - FRAME_TICKS = FRAME_US·TPU (1_000_000 at defaults)
  - MIN_TICKS = MIN_US·TPU
  - STEP_TICKS = ((MAX_US−MIN_US)·TPU)/180, truncated (277 at defaults)
- Width rule: ticks = MIN_TICKS + min(cmd_grades,180)·STEP_TICKS. This is computed at accept time into a 20-bit `pending` register. Angles above 180 saturate to 180.
- Handshake:
  - A command is accepted when `cmd_valid && cmd_ready`.
  - `cmd_ready` = NOT pending_valid, registered.
  - A held `cmd_valid` with ready low is stalled, not dropped.
- States:
  - **IDLE**: after reset. Frame counter stopped, `pwm_out`=0. The first accepted command loads `active` directly and moves the block to RUN. The frame counter is 0 in the next cycle.
  - **RUN**: the 20-bit frame counter counts 0..FRAME_TICKS−1 and wraps.
    - `pwm_out` <= (cnt < active).
    - On wrap to 0, if pending_valid: `active` <= `pending` and pending_valid is cleared.
  - **FAULT**: `pwm_out` forced 0. The frame counter keeps running. `active` and `pending` are retained.
- Over-current:
  - `oc_cnt` increments while `current_ma` > ILIM_MA and saturates at OC_TICKS. It clears to 0 on any cycle at or below the limit.
  - When `oc_cnt` reaches OC_TICKS: `fault`=1 and the state goes RUN→FAULT.
- Fault clear:
  - `fault_clr` is honoured only when `oc_cnt`==0. `fault` clears in the next cycle.
  - The state returns to RUN. Pulses resume at the next frame boundary, never mid-frame.
- Simultaneous events:
  - Accept in the same cycle as a wrap: pending is empty, so the accepted value lands in `pending` and is applied at the following wrap.
  - Fault in the same cycle as a wrap: fault wins and `pwm_out`=0.
- Reset mid-operation: all state is cleared, and the next command restarts from IDLE.

## Timing
- Reset values: `pwm_out`=0, `frame_start`=0, `fault`=0, `cmd_ready`=0 while `rst`=1. `cmd_ready`=1 on the first cycle after release.
- Accept to width effect:
  - From IDLE: `pwm_out` rises 2 cycles after the accept edge.
  - From RUN: at the first frame boundary after the accept.
- `frame_start` is asserted in the same cycle `pwm_out` rises for a frame (cnt==0 registered).
- High time per frame is exactly `active` cycles. Low time is FRAME_TICKS−`active` cycles.
- Fault: `pwm_out` falls in the cycle after `fault` rises, i.e. OC_TICKS+1 cycles after the first over-limit sample.

## Configuration
- `SERVO_OC_PROTECT_EN` defined: the over-current counter, FAULT state and `fault_clr` behave as described above.
- Not defined:
  - `current_ma` and `fault_clr` are ignored and `fault` is tied 0.
  - The FAULT state is unreachable and no `oc_cnt` logic is synthesized.

## Test plan
- Reset 10 ms, then 90° accepted → first `pwm_out` high 74930 cycles, low 925070 cycles, `frame_start` every 1_000_000 cycles.
- 0°, 180° and 200° in separate frames → high times of 50000, 99860 and 99860 cycles respectively, each switching exactly at a `frame_start`.
- Two back-to-back commands (45°, then 135°) mid-frame → `cmd_ready` drops after the first. The second stalls until the wrap. The widths 62465 and 87395 then appear in consecutive frames.
- With `SERVO_OC_PROTECT_EN`, `current_ma`=6000 for 2 ms at 90° → `fault`=1 after 50000 cycles and `pwm_out` stays 0. `fault_clr` while the current is 6000 has no effect. After the current drops to 1000, `fault_clr` clears `fault` and pulses resume at the next `frame_start`.
- `current_ma`=5000 for 49999 cycles, then 2000 → no fault, and the counter is cleared.
- Without `SERVO_OC_PROTECT_EN`, `current_ma`=6000 for 15 ms → `fault` stays 0 and the 74930-cycle pulses continue.
